paddle_sequencer: RTL and testbench
===================================

# paddle_sequencer

Per-frame motion controller for both MAH PONK paddles. On each frame strobe it samples the ball position and the player buttons, picks human or robot control for each paddle, and performs `speed` single-pixel move steps on each paddle, alternating between them. A paddle falls back to robot tracking after a run of idle frames. The block sits between the VGA timing generator (frame strobe), the button synchronisers and the paddle renderer, and takes over all paddle-position control.

## Interface
- `PADDLESIZE`, 10'd64, paddle height in pixels.
- `SCREENHEIGHT`, 10'd480, playfield height in pixels.
- `IDLE_FRAMES`, 8'd180, number of button-free frames before a paddle returns to robot control.
- `clk` input 1: system clock. One clock domain.
- `reset_n` input 1: reset, asynchronous, active-low.
- `frame` input 1: one-cycle pulse at the start of vblank.
- `speed` input 3: move steps per paddle per frame; 0 means no motion.
- `ball_y` input 10: ball centre Y.
- `up` input 2: per-paddle move-up button, already synchronised; bit 0 is paddle 0.
- `down` input 2: per-paddle move-down button, already synchronised.
- `paddle0_y` output 10: paddle 0 centre Y.
- `paddle1_y` output 10: paddle 1 centre Y.
- `robo` output 2: 1 = paddle under robot control.
- `busy` output 1: high while the block is stepping.

## Operation
- The FSM has two states, IDLE and STEP. A registered `sel` bit selects the paddle being updated. An internal counter `cnt[3:0]` holds the remaining step count.
- **IDLE, `frame` sampled high:**
  - Latch `ball_y`, `up`, `down` and `speed`.
  - Per paddle, any button bit set: clear the idle counter and clear `robo[i]`.
  - Per paddle, no button bit set: increment the idle counter, saturating at IDLE_FRAMES. When it reaches IDLE_FRAMES, set `robo[i]`.
  - Load `cnt = 2*speed` and `sel = 0`.
  - Enter STEP if `speed != 0`; otherwise stay in IDLE.
- **STEP, every cycle:**
  - Update the paddle selected by `sel`.
  - Toggle `sel` and decrement `cnt`.
  - When `cnt == 1`, return to IDLE.
- **Human step:** latched up only gives -1. Latched down only gives +1. Both or neither gives 0. The latched buttons stay valid for the whole frame.
- **Robot step** uses the current Y and the latched ball:
  - `ball_y < y - PADDLESIZE/2` gives -1.
  - `ball_y > y + PADDLESIZE/2` gives +1.
  - Otherwise 0 (deadband, inclusive).
- **Arithmetic:**
  - Evaluate in 11 bits.
  - Clamp the result to [PADDLESIZE/2, SCREENHEIGHT-PADDLESIZE/2], i.e. [32, 448] with defaults.
  - The clamped value always fits 10 bits; no wrap-around is possible.
- **Boundary cases:**
  - `frame` while in STEP is ignored. There is no queueing and the idle counters do not advance.
  - Changes to `speed`, `ball_y` or the buttons mid-STEP have no effect until the next accepted frame.

## Timing
- **Reset values (all outputs and state, applied asynchronously):**
  - `paddle0_y = paddle1_y = SCREENHEIGHT/2` (240).
  - `robo = 2'b11`, `busy = 0`, state IDLE, `sel = 0`, `cnt = 0`.
  - Idle counters = IDLE_FRAMES.
- Deasserting `reset_n` mid-STEP aborts the sequence immediately.
- **Step timing**, with `frame` sampled at edge E0:
  - `robo` updates at E0.
  - `busy` rises at E0; it is a registered output equal to (state == STEP).
  - `paddle0_y` updates at E0+1, E0+3, …
  - `paddle1_y` updates at E0+2, E0+4, …
  - The final update is at E0+2·speed, and `busy` falls at that same edge.
- Maximum burst is 14 cycles, which fits in vblank by a wide margin.
- Each output changes by at most one pixel per edge.

## Structure
- **Shared package `pong_pkg`:**
  - SCREENHEIGHT and PADDLESIZE default constants.
  - The `seq_state_t` enum (IDLE, STEP).
  - The `limit_y` clamp function, reused by the ball logic.
- **Sub-module `paddle_step`:**
  - Combinational.
  - Inputs: `y`, `robo`, `up`, `down`, `ball_y`.
  - Output: clamped `next_y`.
  - Instantiated once and muxed by `sel`. Paddles are never updated in parallel.

## Test plan
Defaults apply except IDLE_FRAMES=4.
1. **Reset:** assert `reset_n`=0 mid-cycle. Outputs go immediately to `paddle0_y=paddle1_y=240`, `robo=11`, `busy=0`.
2. **Robot tracking:**
   - Stimulus: `speed=3`, `ball_y=100`, one `frame`.
   - `busy` is high for 6 cycles.
   - `paddle0_y` goes 239, 238, 237 at E0+1/3/5.
   - `paddle1_y` ends at 237 at E0+6.
3. **Human takeover:**
   - Stimulus: `up=01`, `speed=2`, `ball_y=240`, one `frame`.
   - `robo=10`.
   - `paddle0_y=238`.
   - `paddle1_y` stays 240 (inside the deadband).
4. **Idle return:**
   - Stimulus: after test 3, send 4 frames with `up=down=0`.
   - `robo[0]` stays 0 through frame 3 and becomes 1 at the 4th frame's E0.
5. **Clamp:**
   - Stimulus: human `down=01`, `paddle0_y=447`, `speed=4`.
   - `paddle0_y` becomes 448 and stays 448.
   - Repeat upward from 33: the result is 32.
6. **Overlap and abort:**
   - A `frame` pulse at E0+2 with `speed=3` is ignored; the final Y values match test 2.
   - `reset_n`=0 at E0+3 returns Y to 240 and `busy` to 0 with no further steps.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared MAH PONK definitions: playfield geometry, sequencer states and
// the Y clamp used by both paddle and ball logic.
package pong_pkg;

  localparam logic [9:0] SCREENHEIGHT = 10'd480;
  localparam logic [9:0] PADDLESIZE   = 10'd64;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } seq_state_t;

  // Clamp an 11-bit intermediate Y into [lo, hi]; the result always fits 10 bits.
  function automatic logic [9:0] limit_y(
    input logic [10:0] v,
    input logic [9:0]  lo,
    input logic [9:0]  hi
  );
    logic [9:0] res;
    if (v < {1'b0, lo}) begin
      res = lo;
    end else if (v > {1'b0, hi}) begin
      res = hi;
    end else begin
      res = v[9:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/paddle_step.sv
// One single-pixel move decision for a paddle: human buttons or robot
// tracking of the latched ball, followed by a clamp to the playfield.
module paddle_step
  import pong_pkg::*;
#(
  parameter logic [9:0] PADDLESIZE   = pong_pkg::PADDLESIZE,
  parameter logic [9:0] SCREENHEIGHT = pong_pkg::SCREENHEIGHT
) (
  input  logic [9:0] y,
  input  logic       robo,
  input  logic       up,
  input  logic       down,
  input  logic [9:0] ball_y,
  output logic [9:0] next_y
);

  localparam logic [9:0]  Y_LO = PADDLESIZE >> 1;
  localparam logic [9:0]  Y_HI = SCREENHEIGHT - (PADDLESIZE >> 1);
  localparam logic [10:0] HALF = {1'b0, Y_LO};

  logic [10:0] y_ext;
  logic [10:0] ball_ext;
  logic [10:0] sum;
  logic        dec;
  logic        inc;

  // Pick -1/0/+1 and clamp; robot deadband is inclusive on both edges.
  always_comb begin
    y_ext    = {1'b0, y};
    ball_ext = {1'b0, ball_y};
    dec      = 1'b0;
    inc      = 1'b0;
    if (robo) begin
      // ball < y - half rewritten as ball + half < y to avoid underflow
      dec = (ball_ext + HALF) < y_ext;
      inc = ball_ext > (y_ext + HALF);
    end else begin
      dec = up & ~down;
      inc = down & ~up;
    end
    if (dec) begin
      sum = y_ext - 11'd1;
    end else if (inc) begin
      sum = y_ext + 11'd1;
    end else begin
      sum = y_ext;
    end
    next_y = limit_y(sum, Y_LO, Y_HI);
  end

endmodule

// File: rtl/paddle_sequencer.sv
// Per-frame paddle motion controller: on each accepted frame strobe it
// latches inputs, updates human/robot ownership and then interleaves
// speed single-pixel steps on paddle 0 and paddle 1.
module paddle_sequencer
  import pong_pkg::*;
#(
  parameter logic [9:0] PADDLESIZE   = pong_pkg::PADDLESIZE,
  parameter logic [9:0] SCREENHEIGHT = pong_pkg::SCREENHEIGHT,
  parameter logic [7:0] IDLE_FRAMES  = 8'd180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame,
  input  logic [2:0] speed,
  input  logic [9:0] ball_y,
  input  logic [1:0] up,
  input  logic [1:0] down,
  output logic [9:0] paddle0_y,
  output logic [9:0] paddle1_y,
  output logic [1:0] robo,
  output logic       busy
);

  localparam logic [9:0] Y_MID = SCREENHEIGHT >> 1;

  seq_state_t state_reg;
  logic       sel_reg;
  logic [3:0] cnt_reg;
  logic [9:0] paddle0_y_reg;
  logic [9:0] paddle1_y_reg;
  logic       busy_reg;
  logic [9:0] ball_reg;
  logic [1:0] up_reg;
  logic [1:0] down_reg;
  logic [1:0] robo_w;

  logic       accept;
  logic [9:0] cur_y;
  logic [9:0] next_y;

  // A frame is only honoured while idle; strobes during a burst are dropped.
  assign accept = frame && (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_idle
      logic [7:0] idle_cnt_reg;
      logic [7:0] idle_cnt_next;
      logic       robo_bit_reg;

      assign idle_cnt_next = (idle_cnt_reg == IDLE_FRAMES) ? IDLE_FRAMES
                                                           : idle_cnt_reg + 8'd1;

      // Button activity grabs the paddle; a run of quiet frames hands it back to the robot.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          idle_cnt_reg <= IDLE_FRAMES;
          robo_bit_reg <= 1'b1;
        end else if (accept) begin
          if (up[gi] | down[gi]) begin
            idle_cnt_reg <= 8'd0;
            robo_bit_reg <= 1'b0;
          end else begin
            idle_cnt_reg <= idle_cnt_next;
            if (idle_cnt_next == IDLE_FRAMES) begin
              robo_bit_reg <= 1'b1;
            end
          end
        end
      end

      assign robo_w[gi] = robo_bit_reg;
    end
  endgenerate

  // One shared step unit, steered to whichever paddle sel points at.
  assign cur_y = sel_reg ? paddle1_y_reg : paddle0_y_reg;

  paddle_step #(
    .PADDLESIZE   (PADDLESIZE),
    .SCREENHEIGHT (SCREENHEIGHT)
  ) u_step (
    .y      (cur_y),
    .robo   (robo_w[sel_reg]),
    .up     (up_reg[sel_reg]),
    .down   (down_reg[sel_reg]),
    .ball_y (ball_reg),
    .next_y (next_y)
  );

  // Frame sequencer: latch on accepted frame, then 2*speed alternating steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      cnt_reg       <= 4'd0;
      paddle0_y_reg <= Y_MID;
      paddle1_y_reg <= Y_MID;
      busy_reg      <= 1'b0;
      ball_reg      <= 10'd0;
      up_reg        <= 2'b00;
      down_reg      <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame) begin
            ball_reg <= ball_y;
            up_reg   <= up;
            down_reg <= down;
            cnt_reg  <= {speed, 1'b0};
            sel_reg  <= 1'b0;
            if (speed != 3'd0) begin
              state_reg <= STEP;
              busy_reg  <= 1'b1;
            end
          end
        end
        STEP: begin
          if (sel_reg) begin
            paddle1_y_reg <= next_y;
          end else begin
            paddle0_y_reg <= next_y;
          end
          sel_reg <= ~sel_reg;
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign paddle0_y = paddle0_y_reg;
  assign paddle1_y = paddle1_y_reg;
  assign robo      = robo_w;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_paddle_sequencer.sv
// Directed bench for paddle_sequencer (IDLE_FRAMES=4) with a frame-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_paddle_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] ball_y = 10'd240;
  logic [1:0] up = 2'b00;
  logic [1:0] down = 2'b00;
  logic [9:0] paddle0_y;
  logic [9:0] paddle1_y;
  logic [1:0] robo;
  logic       busy;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  localparam int Y_LO = 32;
  localparam int Y_HI = 448;
  localparam int HALF = 32;
  localparam int IDLE_N = 4;

  paddle_sequencer #(
    .IDLE_FRAMES (8'd4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame     (frame),
    .speed     (speed),
    .ball_y    (ball_y),
    .up        (up),
    .down      (down),
    .paddle0_y (paddle0_y),
    .paddle1_y (paddle1_y),
    .robo      (robo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct {
    int p0;
    int p1;
  } snap_t;

  snap_t    q[$];
  int       m_p0;
  int       m_p1;
  bit [1:0] m_robo;
  int       m_idle[2];

  function automatic int model_move(input int y, input bit rb, input bit u,
                                    input bit d, input int ball);
    int n;
    n = y;
    if (rb) begin
      if (ball < y - HALF) n = y - 1;
      else if (ball > y + HALF) n = y + 1;
    end else begin
      if (u && !d) n = y - 1;
      else if (d && !u) n = y + 1;
    end
    if (n < Y_LO) n = Y_LO;
    if (n > Y_HI) n = Y_HI;
    return n;
  endfunction

  task automatic model_reset();
    m_p0 = 240;
    m_p1 = 240;
    m_robo = 2'b11;
    m_idle[0] = IDLE_N;
    m_idle[1] = IDLE_N;
    q.delete();
  endtask

  task automatic model_accept();
    int    y[2];
    snap_t s;
    for (int i = 0; i < 2; i++) begin
      if (up[i] || down[i]) begin
        m_idle[i] = 0;
        m_robo[i] = 1'b0;
      end else begin
        if (m_idle[i] < IDLE_N) m_idle[i]++;
        if (m_idle[i] == IDLE_N) m_robo[i] = 1'b1;
      end
    end
    y[0] = m_p0;
    y[1] = m_p1;
    for (int k = 0; k < 2 * int'(speed); k++) begin
      int i;
      i = k % 2;
      y[i] = model_move(y[i], m_robo[i], up[i], down[i], int'(ball_y));
      s.p0 = y[0];
      s.p1 = y[1];
      q.push_back(s);
    end
  endtask

  // Model advances on the same edges as the DUT.
  initial begin
    snap_t s;
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else if (q.size() != 0) begin
        s = q.pop_front();
        m_p0 = s.p0;
        m_p1 = s.p1;
      end else if (frame) begin
        model_accept();
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking && reset_n) begin
        check("cyc_p0", int'(paddle0_y), m_p0);
        check("cyc_p1", int'(paddle1_y), m_p1);
        check("cyc_robo", int'(robo), int'(m_robo));
        check("cyc_busy", int'(busy), int'(q.size() != 0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_rst_p0"}, int'(paddle0_y), 240);
    check({tag, "_rst_p1"}, int'(paddle1_y), 240);
    check({tag, "_rst_robo"}, int'(robo), 3);
    check({tag, "_rst_busy"}, int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_frame(input int spd, input int ball, input logic [1:0] u,
                           input logic [1:0] d);
    int n;
    @(negedge clk);
    speed = 3'(spd);
    ball_y = 10'(ball);
    up = u;
    down = d;
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: busy still %0d after 40 cycles, expected 0", busy);
    end
    $display("[TB] frame speed=%0d ball=%0d up=%b down=%b -> p0=%0d p1=%0d robo=%b",
             spd, ball, u, d, paddle0_y, paddle1_y, robo);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1: reset applied asynchronously mid-cycle
    #3 reset_n = 1'b0;
    #1;
    check("t1_p0", int'(paddle0_y), 240);
    check("t1_p1", int'(paddle1_y), 240);
    check("t1_robo", int'(robo), 3);
    check("t1_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    checking = 1'b1;

    // 2: robot tracking, speed 3 toward ball at 100
    @(negedge clk);
    speed = 3'd3; ball_y = 10'd100; up = 2'b00; down = 2'b00; frame = 1'b1;
    @(negedge clk); frame = 1'b0;                 // after E0
    check("t2_busy_rise", int'(busy), 1);
    @(negedge clk);                               // after E0+1
    check("t2_p0_e1", int'(paddle0_y), 239);
    check("t2_p1_e1", int'(paddle1_y), 240);
    @(negedge clk);                               // E0+2
    check("t2_p1_e2", int'(paddle1_y), 239);
    @(negedge clk);                               // E0+3
    check("t2_p0_e3", int'(paddle0_y), 238);
    @(negedge clk);                               // E0+4
    @(negedge clk);                               // E0+5
    check("t2_p0_e5", int'(paddle0_y), 237);
    check("t2_busy_e5", int'(busy), 1);
    @(negedge clk);                               // E0+6
    check("t2_p1_e6", int'(paddle1_y), 237);
    check("t2_busy_fall", int'(busy), 0);
    $display("[TB] robot frame -> p0=%0d p1=%0d", paddle0_y, paddle1_y);

    // 3: human takeover of paddle 0
    do_reset("t3");
    run_frame(2, 240, 2'b01, 2'b00);
    check("t3_robo", int'(robo), 2);
    check("t3_p0", int'(paddle0_y), 238);
    check("t3_p1", int'(paddle1_y), 240);

    // 4: idle return after 4 quiet frames
    for (int f = 1; f <= 4; f++) begin
      run_frame(0, 240, 2'b00, 2'b00);
      check($sformatf("t4_robo0_f%0d", f), int'(robo[0]), (f == 4) ? 1 : 0);
    end

    // 5: clamp at bottom then top
    for (int f = 0; f < 29; f++) run_frame(7, 240, 2'b00, 2'b01);
    run_frame(6, 240, 2'b00, 2'b01);
    check("t5_p0_447", int'(paddle0_y), 447);
    run_frame(4, 240, 2'b00, 2'b01);
    check("t5_p0_448a", int'(paddle0_y), 448);
    run_frame(4, 240, 2'b00, 2'b01);
    check("t5_p0_448b", int'(paddle0_y), 448);
    for (int f = 0; f < 59; f++) run_frame(7, 240, 2'b01, 2'b00);
    run_frame(2, 240, 2'b01, 2'b00);
    check("t5_p0_33", int'(paddle0_y), 33);
    run_frame(4, 240, 2'b01, 2'b00);
    check("t5_p0_32", int'(paddle0_y), 32);

    // 6a: overlapping frame ignored, mid-burst input changes ignored
    do_reset("t6a");
    @(negedge clk);
    speed = 3'd3; ball_y = 10'd100; up = 2'b00; down = 2'b00; frame = 1'b1;
    @(negedge clk); frame = 1'b0;                 // E0
    @(negedge clk);                               // E0+1
    frame = 1'b1; speed = 3'd7; ball_y = 10'd400; up = 2'b11;
    @(negedge clk); frame = 1'b0;                 // E0+2 sampled frame
    repeat (4) @(negedge clk);                    // E0+6
    check("t6a_p0", int'(paddle0_y), 237);
    check("t6a_p1", int'(paddle1_y), 237);
    check("t6a_busy", int'(busy), 0);
    check("t6a_robo", int'(robo), 3);
    up = 2'b00;

    // 6b: reset mid-burst aborts
    do_reset("t6b");
    @(negedge clk);
    speed = 3'd3; ball_y = 10'd100; frame = 1'b1;
    @(negedge clk); frame = 1'b0;                 // E0
    repeat (3) @(negedge clk);                    // E0+3
    check("t6b_p0_pre", int'(paddle0_y), 238);
    check("t6b_p1_pre", int'(paddle1_y), 239);
    #1 reset_n = 1'b0;
    #1;
    check("t6b_p0_abort", int'(paddle0_y), 240);
    check("t6b_p1_abort", int'(paddle1_y), 240);
    check("t6b_busy_abort", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6b_p0_after", int'(paddle0_y), 240);
    check("t6b_p1_after", int'(paddle1_y), 240);
    check("t6b_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
